// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface memory_access_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack bus,
// misalignment exceptions, and registered results for writeback.
module memory_access #(
  parameter logic [3:0] LOAD_MISALIGN_CAUSE  = 4'd4,
  parameter logic [3:0] STORE_MISALIGN_CAUSE = 4'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_taken_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  load_store_size_in,
  input  logic        load_signed_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [11:0] csr_addr_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall_in,
  input  logic        invalidate,
  output logic        stall_out,
  output logic [4:0]  data_hazard,
  memory_access_if.master bus,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic        branch_taken_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_addr_out,
  output logic [11:0] csr_addr_out,
  output logic [3:0]  ecause_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic f_misaligned(input logic [1:0] off, input logic [1:0] size);
    f_misaligned = (size == 2'd1 && off[0]) || (size[1] && off != 2'd0);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] rs2, input logic [1:0] size);
    if (size == 2'd0)      f_wdata = {4{rs2[7:0]}};
    else if (size == 2'd1) f_wdata = {2{rs2[15:0]}};
    else                   f_wdata = rs2;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [1:0] off, input logic [1:0] size);
    if (size == 2'd0)      f_wstrb = 4'b0001 << off;
    else if (size == 2'd1) f_wstrb = 4'b0011 << off;
    else                   f_wstrb = 4'b1111;
  endfunction

  // Byte lane selected by the address offset, then sign- or zero-extended.
  function automatic logic [31:0] f_extend(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = rdata >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    if (size == 2'd0) begin
      if (sgn) f_extend = 32'(sb);
      else     f_extend = {24'd0, sh[7:0]};
    end else if (size == 2'd1) begin
      if (sgn) f_extend = 32'(shw);
      else     f_extend = {16'd0, sh[15:0]};
    end else begin
      f_extend = sh;
    end
  endfunction

  state_t      r_state, w_state_nxt;
  logic        w_live, w_access, w_mis, w_start, w_capture, w_emit;
  logic [31:0] w_ld_data, w_emit_data;

  logic        r_mem_req, r_mem_write;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic [31:0] r_b_pc, r_b_next_pc, r_b_alu, r_b_csr_data, r_b_ldata;
  logic        r_b_branch, r_b_mret, r_b_wfi, r_b_sgn, r_b_store, r_b_kill;
  logic [1:0]  r_b_ws, r_b_off, r_b_size;
  logic [4:0]  r_b_rd;
  logic [11:0] r_b_csr_addr;
  logic [3:0]  r_b_ecause;

  assign w_live      = valid_in && !exception_in && !invalidate;
  assign w_access    = w_live && (load_in || store_in);
  assign w_mis       = f_misaligned(alu_data_in[1:0], load_store_size_in);
  assign w_ld_data   = r_b_store ? 32'd0 : f_extend(bus.mem_rdata, r_b_off, r_b_size, r_b_sgn);
  assign w_emit_data = (r_state == S_BUSY) ? w_ld_data : r_b_ldata;
  assign data_hazard = (valid_in && !exception_in) ? rd_addr_in : 5'd0;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    stall_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!stall_in && w_access && !w_mis) begin
          w_start     = 1'b1;
          stall_out   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_out = !bus.mem_ack;
        if (bus.mem_ack) begin
          if (stall_in) begin
            w_capture   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_emit      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DONE: begin
        stall_out = 1'b1;
        if (!stall_in) begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req <= 1'b0;  r_mem_write <= 1'b0;  r_mem_addr <= '0;
      r_mem_wdata <= '0;  r_mem_wstrb <= '0;
      r_b_pc <= '0;  r_b_next_pc <= '0;  r_b_alu <= '0;  r_b_csr_data <= '0;  r_b_ldata <= '0;
      r_b_branch <= 1'b0;  r_b_mret <= 1'b0;  r_b_wfi <= 1'b0;  r_b_sgn <= 1'b0;
      r_b_store <= 1'b0;  r_b_kill <= 1'b0;  r_b_ws <= '0;  r_b_off <= '0;  r_b_size <= '0;
      r_b_rd <= '0;  r_b_csr_addr <= '0;  r_b_ecause <= '0;
      pc_out <= '0;  next_pc_out <= '0;  alu_data_out <= '0;  csr_data_out <= '0;
      load_data_out <= '0;  branch_taken_out <= 1'b0;  mret_out <= 1'b0;  wfi_out <= 1'b0;
      valid_out <= 1'b0;  exception_out <= 1'b0;  write_select_out <= '0;
      rd_addr_out <= '0;  csr_addr_out <= '0;  ecause_out <= '0;
    end else begin
      if (w_start) begin
        r_mem_req    <= 1'b1;
        r_mem_write  <= store_in;
        r_mem_addr   <= {alu_data_in[31:2], 2'b00};
        r_mem_wdata  <= f_wdata(rs2_data_in, load_store_size_in);
        r_mem_wstrb  <= f_wstrb(alu_data_in[1:0], load_store_size_in);
        r_b_pc       <= pc_in;           r_b_next_pc  <= next_pc_in;
        r_b_alu      <= alu_data_in;     r_b_csr_data <= csr_data_in;
        r_b_branch   <= branch_taken_in; r_b_mret     <= mret_in;
        r_b_wfi      <= wfi_in;          r_b_ws       <= write_select_in;
        r_b_rd       <= rd_addr_in;      r_b_csr_addr <= csr_addr_in;
        r_b_ecause   <= ecause_in;       r_b_off      <= alu_data_in[1:0];
        r_b_size     <= load_store_size_in;
        r_b_sgn      <= load_signed_in;  r_b_store    <= store_in;
        r_b_kill     <= 1'b0;
        // Bubble downstream while the bus transaction is in flight.
        valid_out    <= 1'b0;
      end else if (r_state == S_IDLE && !stall_in) begin
        pc_out           <= pc_in;           next_pc_out  <= next_pc_in;
        alu_data_out     <= alu_data_in;     csr_data_out <= csr_data_in;
        branch_taken_out <= branch_taken_in; mret_out     <= mret_in;
        wfi_out          <= wfi_in;          write_select_out <= write_select_in;
        rd_addr_out      <= rd_addr_in;      csr_addr_out <= csr_addr_in;
        load_data_out    <= 32'd0;
        if (w_access) begin
          valid_out     <= 1'b1;
          exception_out <= 1'b1;
          ecause_out    <= store_in ? STORE_MISALIGN_CAUSE : LOAD_MISALIGN_CAUSE;
        end else begin
          valid_out     <= valid_in && !invalidate;
          exception_out <= exception_in;
          ecause_out    <= ecause_in;
        end
      end
      if (r_state == S_BUSY && bus.mem_ack) r_mem_req <= 1'b0;
      if (w_capture) r_b_ldata <= w_ld_data;
      if (r_state != S_IDLE && invalidate) r_b_kill <= 1'b1;
      if (w_emit) begin
        pc_out           <= r_b_pc;       next_pc_out  <= r_b_next_pc;
        alu_data_out     <= r_b_alu;      csr_data_out <= r_b_csr_data;
        branch_taken_out <= r_b_branch;   mret_out     <= r_b_mret;
        wfi_out          <= r_b_wfi;      write_select_out <= r_b_ws;
        rd_addr_out      <= r_b_rd;       csr_addr_out <= r_b_csr_addr;
        ecause_out       <= r_b_ecause;   exception_out <= 1'b0;
        load_data_out    <= w_emit_data;
        valid_out        <= !(r_b_kill || invalidate);
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized loads/stores
// checked against an arithmetic reference of the access rules.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        branch_taken_in, load_in, store_in, load_signed_in;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_addr_in;
  logic [11:0] csr_addr_in;
  logic        mret_in, wfi_in, valid_in, exception_in, stall_in, invalidate;
  logic [3:0]  ecause_in;
  logic        stall_out;
  logic [4:0]  data_hazard;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic        branch_taken_out, mret_out, wfi_out, valid_out, exception_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_addr_out;
  logic [11:0] csr_addr_out;
  logic [3:0]  ecause_out;

  int n_pass  = 0;
  int n_total = 0;

  memory_access_if mif ();

  memory_access dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
    .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
    .write_select_in(write_select_in), .rd_addr_in(rd_addr_in), .csr_addr_in(csr_addr_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .stall_in(stall_in), .invalidate(invalidate),
    .stall_out(stall_out), .data_hazard(data_hazard), .bus(mif),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .load_data_out(load_data_out),
    .branch_taken_out(branch_taken_out), .mret_out(mret_out), .wfi_out(wfi_out),
    .valid_out(valid_out), .exception_out(exception_out),
    .write_select_out(write_select_out), .rd_addr_out(rd_addr_out),
    .csr_addr_out(csr_addr_out), .ecause_out(ecause_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  // Reference: pick nbytes starting at byte addr%4, then extend arithmetically.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int nb, input bit sgn);
    longint v;
    longint span;
    span = longint'(1) << (8 * nb);
    v = longint'(rdata);
    v = (v >> (8 * (addr % 4))) % span;
    if (sgn && nb < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int nb);
    if (nb == 1) return (rs2 % 256) * 32'h01010101;
    if (nb == 2) return (rs2 % 65536) * 32'h00010001;
    return rs2;
  endfunction

  task automatic clear_inputs();
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; load_signed_in = 1'b0;
    load_store_size_in = 2'd0; exception_in = 1'b0; ecause_in = 4'd0;
    stall_in = 1'b0; invalidate = 1'b0; mret_in = 1'b0; wfi_in = 1'b0;
    pc_in = 32'd0; next_pc_in = 32'd0; alu_data_in = 32'd0; rs2_data_in = 32'd0;
    csr_data_in = 32'd0; branch_taken_in = 1'b0; write_select_in = 2'd0;
    rd_addr_in = 5'd0; csr_addr_in = 12'd0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
  endtask

  task automatic drive_op(input bit ld, input bit st, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
    valid_in = 1'b1; exception_in = 1'b0; invalidate = 1'b0;
    load_in = ld; store_in = st; load_store_size_in = size; load_signed_in = sgn;
    alu_data_in = addr; rs2_data_in = rs2; rd_addr_in = rd;
    pc_in = $urandom; next_pc_in = pc_in + 32'd4; csr_data_in = $urandom;
    csr_addr_in = 12'($urandom); branch_taken_in = 1'($urandom);
    write_select_in = 2'($urandom); ecause_in = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_out); else n_pass++;
    n_total++; if (mif.mem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", mif.mem_req); else n_pass++;
    n_total++; if (stall_out !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall_out); else n_pass++;
    n_total++; if (pc_out !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc_out); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [31:0] pc0;
    @(negedge clk);
    drive_op(0, 0, 2'd0, 0, $urandom, $urandom, 5'd17);
    pc0 = pc_in;
    #1;
    n_total++; if (data_hazard !== 5'd17) $display("FAIL pt_hazard: got %0d want 17", data_hazard); else n_pass++;
    n_total++; if (stall_out !== 1'b0) $display("FAIL pt_stall: got %0b want 0", stall_out); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_out !== pc0) $display("FAIL pt_pc: got %h want %h", pc_out, pc0); else n_pass++;
    n_total++; if (alu_data_out !== alu_data_in) $display("FAIL pt_alu: got %h want %h", alu_data_out, alu_data_in); else n_pass++;
    n_total++; if (valid_out !== 1'b1) $display("FAIL pt_valid: got %0b want 1", valid_out); else n_pass++;
    n_total++; if (ecause_out !== ecause_in) $display("FAIL pt_ecause: got %0d want %0d", ecause_out, ecause_in); else n_pass++;
    stall_in = 1'b1; pc_in = pc0 ^ 32'hFFFF0000;
    @(negedge clk);
    n_total++; if (pc_out !== pc0) $display("FAIL pt_stall_hold: got %h want %h", pc_out, pc0); else n_pass++;
    stall_in = 1'b0; invalidate = 1'b1;
    @(negedge clk);
    n_total++; if (valid_out !== 1'b0) $display("FAIL pt_inval: got %0b want 0", valid_out); else n_pass++;
    n_total++; if (pc_out !== (pc0 ^ 32'hFFFF0000)) $display("FAIL pt_pc2: got %h want %h", pc_out, pc0 ^ 32'hFFFF0000); else n_pass++;
    invalidate = 1'b0; exception_in = 1'b1;
    #1;
    n_total++; if (data_hazard !== 5'd0) $display("FAIL pt_hazard_exc: got %0d want 0", data_hazard); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_lw_wait();
    logic [31:0] pc0;
    int req_cycles;
    @(negedge clk);
    drive_op(1, 0, 2'd2, 0, 32'h100, 32'd0, 5'd7);
    pc0 = pc_in;
    #1;
    n_total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_req: got %0b want 1", stall_out); else n_pass++;
    req_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mif.mem_req === 1'b1) req_cycles++;
      if (c == 2) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
        #1;
        n_total++; if (stall_out !== 1'b0) $display("FAIL lw_stall_ack: got %0b want 0", stall_out); else n_pass++;
      end else begin
        n_total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_wait: got %0b want 1", stall_out); else n_pass++;
      end
    end
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_total++; if (req_cycles !== 3) $display("FAIL lw_req_cycles: got %0d want 3", req_cycles); else n_pass++;
    n_total++; if (mif.mem_req !== 1'b0) $display("FAIL lw_req_drop: got %0b want 0", mif.mem_req); else n_pass++;
    n_total++; if (load_data_out !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", load_data_out); else n_pass++;
    n_total++; if (valid_out !== 1'b1) $display("FAIL lw_valid: got %0b want 1", valid_out); else n_pass++;
    n_total++; if (pc_out !== pc0) $display("FAIL lw_pc: got %h want %h", pc_out, pc0); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_lb();
    logic [31:0] exp_lb [2];
    exp_lb[0] = 32'h00000080;
    exp_lb[1] = 32'hFFFFFF80;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      drive_op(1, 0, 2'd0, s[0], 32'h103, 32'd0, 5'd4);
      @(negedge clk);
      n_total++; if (mif.mem_addr !== 32'h100) $display("FAIL lb_addr: got %h want 100", mif.mem_addr); else n_pass++;
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80123456;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      n_total++; if (load_data_out !== exp_lb[s]) $display("FAIL lb_data sgn=%0d: got %h want %h", s, load_data_out, exp_lb[s]); else n_pass++;
      clear_inputs();
    end
  endtask

  task automatic test_store();
    logic [31:0] addr_t [2];
    logic [31:0] rs2_t  [2];
    logic [1:0]  size_t [2];
    logic [3:0]  strb_t [2];
    logic [31:0] wd_t   [2];
    addr_t[0] = 32'h101; rs2_t[0] = 32'h000000AB; size_t[0] = 2'd0; strb_t[0] = 4'b0010; wd_t[0] = 32'hABABABAB;
    addr_t[1] = 32'h102; rs2_t[1] = 32'h1234CDEF; size_t[1] = 2'd1; strb_t[1] = 4'b1100; wd_t[1] = 32'hCDEFCDEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_op(0, 1, size_t[i], 0, addr_t[i], rs2_t[i], 5'd0);
      @(negedge clk);
      n_total++; if (mif.mem_write !== 1'b1) $display("FAIL st_write %0d: got %0b want 1", i, mif.mem_write); else n_pass++;
      n_total++; if (mif.mem_wstrb !== strb_t[i]) $display("FAIL st_wstrb %0d: got %b want %b", i, mif.mem_wstrb, strb_t[i]); else n_pass++;
      n_total++; if (mif.mem_wdata !== wd_t[i]) $display("FAIL st_wdata %0d: got %h want %h", i, mif.mem_wdata, wd_t[i]); else n_pass++;
      n_total++; if (mif.mem_addr !== 32'h100) $display("FAIL st_addr %0d: got %h want 100", i, mif.mem_addr); else n_pass++;
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h55555555;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      n_total++; if (valid_out !== 1'b1) $display("FAIL st_valid %0d: got %0b want 1", i, valid_out); else n_pass++;
      n_total++; if (load_data_out !== 32'd0) $display("FAIL st_ldata %0d: got %h want 0", i, load_data_out); else n_pass++;
      clear_inputs();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr_t [2];
    logic [1:0]  size_t [2];
    logic [3:0]  cause_t [2];
    addr_t[0] = 32'h102; size_t[0] = 2'd2; cause_t[0] = 4'd4;
    addr_t[1] = 32'h201; size_t[1] = 2'd1; cause_t[1] = 4'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_op(i == 0, i == 1, size_t[i], 0, addr_t[i], 32'h0, 5'd3);
      #1;
      n_total++; if (stall_out !== 1'b0) $display("FAIL mis_stall %0d: got %0b want 0", i, stall_out); else n_pass++;
      @(negedge clk);
      n_total++; if (mif.mem_req !== 1'b0) $display("FAIL mis_req %0d: got %0b want 0", i, mif.mem_req); else n_pass++;
      n_total++; if (valid_out !== 1'b1) $display("FAIL mis_valid %0d: got %0b want 1", i, valid_out); else n_pass++;
      n_total++; if (exception_out !== 1'b1) $display("FAIL mis_exc %0d: got %0b want 1", i, exception_out); else n_pass++;
      n_total++; if (ecause_out !== cause_t[i]) $display("FAIL mis_ecause %0d: got %0d want %0d", i, ecause_out, cause_t[i]); else n_pass++;
      clear_inputs();
    end
  endtask

  task automatic test_invalidate();
    logic [31:0] rd_v;
    rd_v = $urandom;
    @(negedge clk);
    drive_op(1, 0, 2'd2, 0, 32'h200, 32'd0, 5'd12);
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0; mif.mem_ack = 1'b1; mif.mem_rdata = rd_v;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_total++; if (mif.mem_req !== 1'b0) $display("FAIL inv_req: got %0b want 0", mif.mem_req); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL inv_valid: got %0b want 0", valid_out); else n_pass++;
    n_total++; if (load_data_out !== rd_v) $display("FAIL inv_data: got %h want %h", load_data_out, rd_v); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_stall_ack();
    logic [31:0] r1, prev;
    r1 = $urandom;
    @(negedge clk);
    drive_op(1, 0, 2'd2, 0, 32'h300, 32'd0, 5'd9);
    prev = load_data_out;
    @(negedge clk);
    mif.mem_ack = 1'b1; mif.mem_rdata = r1; stall_in = 1'b1;
    @(negedge clk);
    n_total++; if (mif.mem_req !== 1'b0) $display("FAIL sa_req: got %0b want 0", mif.mem_req); else n_pass++;
    n_total++; if (stall_out !== 1'b1) $display("FAIL sa_stall: got %0b want 1", stall_out); else n_pass++;
    n_total++; if (load_data_out !== prev) $display("FAIL sa_hold: got %h want %h", load_data_out, prev); else n_pass++;
    mif.mem_rdata = ~r1;
    @(negedge clk);
    n_total++; if (stall_out !== 1'b1) $display("FAIL sa_stall2: got %0b want 1", stall_out); else n_pass++;
    n_total++; if (load_data_out !== prev) $display("FAIL sa_hold2: got %h want %h", load_data_out, prev); else n_pass++;
    mif.mem_ack = 1'b0; stall_in = 1'b0;
    @(negedge clk);
    n_total++; if (load_data_out !== r1) $display("FAIL sa_data: got %h want %h", load_data_out, r1); else n_pass++;
    n_total++; if (valid_out !== 1'b1) $display("FAIL sa_valid: got %0b want 1", valid_out); else n_pass++;
    n_total++; if (rd_addr_out !== 5'd9) $display("FAIL sa_rd: got %0d want 9", rd_addr_out); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] r2;
    r2 = $urandom;
    @(negedge clk);
    drive_op(1, 0, 2'd2, 0, 32'h400, 32'd0, 5'd21);
    @(negedge clk);
    n_total++; if (mif.mem_req !== 1'b1) $display("FAIL rb_req_before: got %0b want 1", mif.mem_req); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (mif.mem_req !== 1'b0) $display("FAIL rb_req: got %0b want 0", mif.mem_req); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL rb_valid: got %0b want 0", valid_out); else n_pass++;
    n_total++; if (load_data_out !== 32'd0) $display("FAIL rb_ldata: got %h want 0", load_data_out); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    drive_op(1, 0, 2'd2, 0, 32'h404, 32'd0, 5'd3);
    @(negedge clk);
    n_total++; if (mif.mem_addr !== 32'h404) $display("FAIL rb_next_addr: got %h want 404", mif.mem_addr); else n_pass++;
    mif.mem_ack = 1'b1; mif.mem_rdata = r2;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_total++; if (load_data_out !== r2) $display("FAIL rb_next_data: got %h want %h", load_data_out, r2); else n_pass++;
    n_total++; if (valid_out !== 1'b1) $display("FAIL rb_next_valid: got %0b want 1", valid_out); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    bit          ld, st, sgn, mis;
    logic [1:0]  size;
    logic [31:0] addr, rs2, rdata, exp_pc, exp_npc, exp_ld;
    logic [4:0]  rd;
    int          nb, waits;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      ld = 1'($urandom_range(0, 1)); st = !ld; sgn = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom; rs2 = $urandom; rdata = $urandom;
      rd = 5'($urandom); waits = $urandom_range(0, 3);
      drive_op(ld, st, size, sgn, addr, rs2, rd);
      exp_pc = pc_in; exp_npc = next_pc_in;
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mis = (addr % nb) != 0;
      #1;
      n_total++; if (stall_out !== !mis) $display("FAIL rnd_stall it=%0d: got %0b want %0b", it, stall_out, !mis); else n_pass++;
      if (mis) begin
        @(negedge clk);
        n_total++; if (mif.mem_req !== 1'b0) $display("FAIL rnd_mis_req it=%0d: got %0b want 0", it, mif.mem_req); else n_pass++;
        n_total++; if (exception_out !== 1'b1) $display("FAIL rnd_mis_exc it=%0d: got %0b want 1", it, exception_out); else n_pass++;
        n_total++; if (ecause_out !== (st ? 4'd6 : 4'd4)) $display("FAIL rnd_mis_cause it=%0d: got %0d want %0d", it, ecause_out, st ? 6 : 4); else n_pass++;
      end else begin
        for (int c = 0; c <= waits; c++) begin
          @(negedge clk);
          n_total++; if (mif.mem_req !== 1'b1) $display("FAIL rnd_req it=%0d c=%0d: got %0b want 1", it, c, mif.mem_req); else n_pass++;
          n_total++; if (mif.mem_addr !== addr - (addr % 4)) $display("FAIL rnd_addr it=%0d: got %h want %h", it, mif.mem_addr, addr - (addr % 4)); else n_pass++;
          n_total++; if (mif.mem_write !== st) $display("FAIL rnd_write it=%0d: got %0b want %0b", it, mif.mem_write, st); else n_pass++;
          if (st) begin
            n_total++; if (mif.mem_wstrb !== 4'(((1 << nb) - 1) << (addr % 4))) $display("FAIL rnd_wstrb it=%0d: got %b want %b", it, mif.mem_wstrb, 4'(((1 << nb) - 1) << (addr % 4))); else n_pass++;
            n_total++; if (mif.mem_wdata !== model_wdata(rs2, nb)) $display("FAIL rnd_wdata it=%0d: got %h want %h", it, mif.mem_wdata, model_wdata(rs2, nb)); else n_pass++;
          end
          if (c == waits) begin
            mif.mem_ack = 1'b1; mif.mem_rdata = rdata;
          end
        end
        @(negedge clk);
        mif.mem_ack = 1'b0;
        exp_ld = st ? 32'd0 : model_load(rdata, addr, nb, sgn);
        n_total++; if (load_data_out !== exp_ld) $display("FAIL rnd_ldata it=%0d: got %h want %h", it, load_data_out, exp_ld); else n_pass++;
        n_total++; if (valid_out !== 1'b1) $display("FAIL rnd_valid it=%0d: got %0b want 1", it, valid_out); else n_pass++;
        n_total++; if (exception_out !== 1'b0) $display("FAIL rnd_exc it=%0d: got %0b want 0", it, exception_out); else n_pass++;
        n_total++; if (pc_out !== exp_pc || next_pc_out !== exp_npc) $display("FAIL rnd_pc it=%0d: got %h/%h want %h/%h", it, pc_out, next_pc_out, exp_pc, exp_npc); else n_pass++;
        n_total++; if (rd_addr_out !== rd || alu_data_out !== addr) $display("FAIL rnd_rd_alu it=%0d: got %0d/%h want %0d/%h", it, rd_addr_out, alu_data_out, rd, addr); else n_pass++;
        n_total++; if (mif.mem_req !== 1'b0) $display("FAIL rnd_req_drop it=%0d: got %0b want 0", it, mif.mem_req); else n_pass++;
      end
      clear_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw_wait();
    test_lb();
    test_store();
    test_misaligned();
    test_invalidate();
    test_stall_ack();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM pipeline stage; consumes the registered execute-stage outputs and drives the data-memory bus.
- Performs byte/half/word loads and stores over a request/acknowledge bus, aligns store data and byte strobes, and sign- or zero-extends load data.
- Raises misaligned-address exceptions and registers the results for writeback.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- LOAD_MISALIGN_CAUSE, 4, ecause written for a misaligned load.
- STORE_MISALIGN_CAUSE, 6, ecause written for a misaligned store.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in, next_pc_in  in  32  passthrough.
- alu_data_in  in  32  effective address, or ALU result for non-memory ops.
- rs2_data_in  in  32  store data.
- csr_data_in  in  32  passthrough.
- branch_taken_in  in  1  passthrough.
- load_in, store_in  in  1  access type.
- load_store_size_in  in  2  0 = byte, 1 = half, 2/3 = word.
- load_signed_in  in  1  sign-extend loads.
- write_select_in  in  2  passthrough.
- rd_addr_in  in  5  passthrough.
- csr_addr_in  in  12  passthrough.
- mret_in, wfi_in  in  1  passthrough.
- valid_in, exception_in  in  1  upstream status.
- ecause_in  in  4  upstream status.
- stall_in  in  1  downstream hold.
- invalidate  in  1  flush the instruction in this stage.
- stall_out  out  1  hold upstream stages.
- data_hazard  out  5  rd of the live instruction in this stage, else 0.
- mem_req  out  1  bus request (registered).
- mem_write  out  1  1 = store.
- mem_addr  out  32  word-aligned bus address.
- mem_wdata  out  32  lane-shifted store data.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read word.
- pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out  out  32  registered results.
- branch_taken_out, mret_out, wfi_out, valid_out, exception_out  out  1  registered status.
- write_select_out  out  2  registered.
- rd_addr_out  out  5  registered.
- csr_addr_out  out  12  registered.
- ecause_out  out  4  registered.

Behaviour:
- Reset (async): all outputs 0; FSM in IDLE; mem_req 0. Reset mid-transaction abandons it with no output update.
- live = valid_in && !exception_in && !invalidate.
- access = live && (load_in || store_in).
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- data_hazard = rd_addr_in when valid_in && !exception_in, else 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, stall_in = 1: hold all registers.
- IDLE, access and misaligned: no bus request. Register passthroughs, valid_out = 1, exception_out = 1, ecause_out = LOAD_/STORE_MISALIGN_CAUSE. Single cycle.
- IDLE, access and aligned:
  - Set mem_req = 1, mem_write = store_in, mem_addr = {addr[31:2], 2'b00}.
  - mem_wdata = rs2 replicated per size: byte {4{b}}, half {2{h}}.
  - mem_wstrb: byte 0001 << addr[1:0]; half 0011 << addr[1:0]; word 1111.
  - Latch all passthroughs plus addr[1:0], size and sign into an internal buffer. Go to BUSY.
- IDLE, non-access or not live: register passthroughs; valid_out = valid_in && !invalidate; exception/ecause pass through. Latency 1.
- stall_out = (IDLE && access && aligned && !stall_in) || (BUSY && !mem_ack) || DONE.
- BUSY:
  - mem_req and address/data/strobe stay stable until mem_ack.
  - On mem_ack: mem_req <= 0. Compute load data: byte = rdata >> (8*addr[1:0]), half = rdata >> (8*addr[1:0]); extend to 32 bits, sign if load_signed else zero.
  - If !stall_in: update outputs (valid_out = 1, load_data_out) and go to IDLE.
  - Else: hold the result in the buffer and go to DONE.
- DONE: when !stall_in, update outputs from the buffer and go to IDLE.
- invalidate during BUSY/DONE: the bus transaction completes (no abort), but the result is emitted with valid_out = 0. The stored data is still written by the store.
- Stores: load_data_out = 0. alu_data_out always = alu_data_in.
- Minimum load/store latency: 2 cycles (request, then ack cycle). Each ack-wait cycle adds 1.
- mem_ack outside BUSY is ignored.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ack after 2 wait cycles -> mem_req high 3 cycles, wstrb irrelevant, load_data_out = 0xDEADBEEF, stall_out high until the ack cycle.
- LB signed addr 0x103, rdata 0x80123456 -> mem_addr 0x100, load_data_out 0xFFFFFF80. Same access with LBU -> 0x00000080.
- SB addr 0x101, rs2 0x000000AB -> mem_write 1, wstrb 0010, wdata 0xABABABAB. SH addr 0x102 -> wstrb 1100.
- LW addr 0x102 -> no mem_req, exception_out 1, ecause_out 4. SH addr 0x201 -> ecause 6.
- Load in BUSY with invalidate pulse, then ack -> mem_req drops, valid_out 0. Ack while stall_in = 1 -> outputs held until stall_in drops, then load_data_out updates.
- Reset asserted mid-BUSY -> mem_req 0 and valid_out 0 immediately; next access after reset behaves normally.
